// File: rtl/jedro_1_prefetch_buf.sv
`default_nettype none
// ============================================================================
//  Module   : jedro_1_prefetch_buf
//  Purpose  : Instruction prefetch buffer for the jedro_1 core. Issues
//             sequential word reads to the instruction RAM ahead of use,
//             queues the returned words in a DEPTH-entry FIFO and presents
//             {instr, addr} to fetch/decode over a valid/ready handshake.
//             A flush redirects fetch and discards all stale data.
//  Ports    : clk_i, rstn_i            clock, async active-low reset
//             flush_i, flush_addr_i    redirect request and byte target
//             ram_en_o, ram_addr_o     RAM read request (word aligned)
//             ram_rdata_i              RAM read data, one cycle after request
//             instr_o, addr_o, valid_o head-of-FIFO entry
//             ready_i                  consumer accepts head
//             misalign_o               only with JEDRO_1_PREFETCH_MISALIGN_EN:
//                                      one-cycle pulse for an unaligned target
//  Config   : JEDRO_1_PREFETCH_MISALIGN_EN (optional misalign_o port)
//  Revision : 1.0 - initial release
// ============================================================================
module jedro_1_prefetch_buf #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [DATA_WIDTH-1:0] BOOT_ADDR  = '0
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] flush_addr_i,
   output logic                  ram_en_o,
   output logic [DATA_WIDTH-1:0] ram_addr_o,
   input  logic [DATA_WIDTH-1:0] ram_rdata_i,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [DATA_WIDTH-1:0] addr_o,
   output logic                  valid_o,
   input  logic                  ready_i
`ifdef JEDRO_1_PREFETCH_MISALIGN_EN
   ,
   output logic                  misalign_o
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   typedef enum logic [0:0] {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic                  inflight_q, inflight_d;
   logic [DATA_WIDTH-1:0] issue_addr_q, issue_addr_d;
   logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] instr_mem_d [DEPTH];
   logic [DATA_WIDTH-1:0] addr_mem_q  [DEPTH];
   logic [DATA_WIDTH-1:0] addr_mem_d  [DEPTH];
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  misalign_q, misalign_d;

   logic [CW:0]           used;
   logic                  issue;
   logic                  push;
   logic                  pop;

   // Credit check counts the outstanding read as occupied, so a response
   // always finds a free slot. A pop in the same cycle is deliberately not
   // credited to keep the enable off the consumer's ready path.
   assign used     = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
   assign issue    = (state_q == ST_RUN) & ~flush_i & (used < DEPTH_C);
   assign push     = inflight_q & ~flush_i;
   assign pop      = valid_o & ready_i & ~flush_i;

   assign ram_en_o   = issue;
   assign ram_addr_o = pc_q;
   assign valid_o    = (count_q != '0);
   assign instr_o    = instr_mem_q[rd_ptr_q];
   assign addr_o     = addr_mem_q[rd_ptr_q];

`ifdef JEDRO_1_PREFETCH_MISALIGN_EN
   assign misalign_o = misalign_q;
`else
   // Target byte offset is dropped silently when misalign reporting is off.
   logic unused_flush_bits;
   assign unused_flush_bits = ^{flush_addr_i[1:0], misalign_q};
`endif

   always_comb begin
      state_d      = ST_RUN;
      pc_d         = pc_q;
      inflight_d   = 1'b0;
      issue_addr_d = issue_addr_q;
      instr_mem_d  = instr_mem_q;
      addr_mem_d   = addr_mem_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      misalign_d   = flush_i & (flush_addr_i[1:0] != 2'b00);

      if (flush_i) begin
         // Redirect wins over everything: pending response, pop and request
         // in this cycle are all discarded.
         pc_d     = {flush_addr_i[DATA_WIDTH-1:2], 2'b00};
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (issue) begin
            pc_d         = pc_q + DATA_WIDTH'(4);
            inflight_d   = 1'b1;
            issue_addr_d = pc_q;
         end
         if (push) begin
            instr_mem_d[wr_ptr_q] = ram_rdata_i;
            addr_mem_d[wr_ptr_q]  = issue_addr_q;
            wr_ptr_d              = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q      <= ST_BOOT;
         pc_q         <= BOOT_ADDR;
         inflight_q   <= 1'b0;
         issue_addr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem_q[i] <= '0;
            addr_mem_q[i]  <= '0;
         end
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         misalign_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inflight_q   <= inflight_d;
         issue_addr_q <= issue_addr_d;
         instr_mem_q  <= instr_mem_d;
         addr_mem_q   <= addr_mem_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         misalign_q   <= misalign_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_jedro_1_prefetch_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jedro_1_prefetch_buf
//  Purpose  : Self-checking bench for jedro_1_prefetch_buf: directed vector
//             tables, hand sequences for flush/wrap/reset corners and a
//             randomized phase checked against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jedro_1_prefetch_buf;

   localparam int DEPTH = 4;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        flush_i;
   logic [31:0] flush_addr_i;
   logic        ram_en_o;
   logic [31:0] ram_addr_o;
   logic [31:0] ram_rdata_i;
   logic [31:0] instr_o;
   logic [31:0] addr_o;
   logic        valid_o;
   logic        ready_i;
`ifdef JEDRO_1_PREFETCH_MISALIGN_EN
   logic        misalign_o;
`endif

   jedro_1_prefetch_buf #(
      .DATA_WIDTH(32),
      .DEPTH     (DEPTH),
      .BOOT_ADDR (32'h0000_0000)
   ) dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .flush_i     (flush_i),
      .flush_addr_i(flush_addr_i),
      .ram_en_o    (ram_en_o),
      .ram_addr_o  (ram_addr_o),
      .ram_rdata_i (ram_rdata_i),
      .instr_o     (instr_o),
      .addr_o      (addr_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i)
`ifdef JEDRO_1_PREFETCH_MISALIGN_EN
      ,
      .misalign_o  (misalign_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // Instruction content is a fixed function of the word address.
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
   endfunction

   // Synchronous RAM: data one cycle after the request, garbage otherwise.
   always @(posedge clk_i) begin
      if (ram_en_o) ram_rdata_i <= mem_f(ram_addr_o);
      else          ram_rdata_i <= $urandom;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue of buffered addresses plus one outstanding read.
   logic [31:0] m_q[$];
   bit          m_pend;
   logic [31:0] m_pend_a;
   logic [31:0] m_pc;
   bit          m_run;
   bit          m_mis;
   bit          m_en;

   task automatic model_reset();
      m_q.delete();
      m_pend = 0; m_pend_a = '0; m_pc = 32'h0; m_run = 0; m_mis = 0;
   endtask

   task automatic drive(input bit fl, input logic [31:0] fa, input bit rdy);
      flush_i = fl; flush_addr_i = fa; ready_i = rdy;
      #1;
   endtask

   task automatic check_model();
      m_en = m_run && !flush_i && ((m_q.size() + int'(m_pend)) < DEPTH);
      chk("ram_en", {31'b0, ram_en_o}, {31'b0, m_en});
      chk("ram_addr", ram_addr_o, m_pc);
      chk("valid", {31'b0, valid_o}, {31'b0, (m_q.size() != 0)});
      if (m_q.size() != 0) begin
         chk("addr_o", addr_o, m_q[0]);
         chk("instr_o", instr_o, mem_f(m_q[0]));
      end
`ifdef JEDRO_1_PREFETCH_MISALIGN_EN
      chk("misalign", {31'b0, misalign_o}, {31'b0, m_mis});
`endif
   endtask

   // Advance the model across the coming clock edge, then wait to the next
   // negative edge where inputs are driven and outputs checked.
   task automatic advance();
      m_mis = flush_i && (flush_addr_i[1:0] != 2'b00);
      if (!m_run) begin
         m_run = 1;
      end else if (flush_i) begin
         m_q.delete();
         m_pend = 0;
         m_pc   = {flush_addr_i[31:2], 2'b00};
      end else begin
         if (m_q.size() != 0 && ready_i) void'(m_q.pop_front());
         if (m_pend) m_q.push_back(m_pend_a);
         m_pend   = m_en;
         m_pend_a = m_pc;
         if (m_en) m_pc = m_pc + 32'd4;
      end
      @(negedge clk_i);
   endtask

   task automatic step(input bit fl, input logic [31:0] fa, input bit rdy);
      drive(fl, fa, rdy);
      check_model();
      advance();
   endtask

   typedef struct {
      bit          ready;
      bit          en;
      logic [31:0] raddr;
      bit          valid;
      logic [31:0] aout;
   } vec_t;

   vec_t t1[6];
   vec_t t2[12];

   task automatic apply_vec(input string tag, input vec_t v);
      drive(1'b0, 32'h0, v.ready);
      chk({tag, ".en"},    {31'b0, ram_en_o}, {31'b0, v.en});
      chk({tag, ".raddr"}, ram_addr_o, v.raddr);
      chk({tag, ".valid"}, {31'b0, valid_o}, {31'b0, v.valid});
      chk({tag, ".aout"},  addr_o, v.aout);
      check_model();
      advance();
   endtask

   task automatic release_reset();
      @(negedge clk_i);
      rstn_i = 1'b1;
      model_reset();
   endtask

   initial begin
      // Test 1: ready high from reset.
      t1[0] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
      t1[1] = '{1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
      t1[2] = '{1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
      t1[3] = '{1'b1, 1'b1, 32'h8,  1'b1, 32'h0};
      t1[4] = '{1'b1, 1'b1, 32'hC,  1'b1, 32'h4};
      t1[5] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
      // Test 2: ready low from reset, fill, then drain without gaps.
      t2[0]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
      t2[1]  = '{1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
      t2[2]  = '{1'b0, 1'b1, 32'h4,  1'b0, 32'h0};
      t2[3]  = '{1'b0, 1'b1, 32'h8,  1'b1, 32'h0};
      t2[4]  = '{1'b0, 1'b1, 32'hC,  1'b1, 32'h0};
      t2[5]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
      t2[6]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
      t2[7]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h0};
      t2[8]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h4};
      t2[9]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h8};
      t2[10] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'hC};
      t2[11] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};

      rstn_i = 1'b0; flush_i = 1'b0; flush_addr_i = '0; ready_i = 1'b0;
      model_reset();
      repeat (3) @(negedge clk_i);
      #1;
      chk("rst.valid", {31'b0, valid_o}, 32'h0);
      chk("rst.en", {31'b0, ram_en_o}, 32'h0);
      chk("rst.raddr", ram_addr_o, 32'h0);
      chk("rst.instr", instr_o, 32'h0);
      chk("rst.addr", addr_o, 32'h0);

      // Test 2 then test 3 (flush of a full FIFO).
      release_reset();
      for (int i = 0; i < 12; i++) apply_vec("t2", t2[i]);
      repeat (6) step(1'b0, 32'h0, 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      chk("full.valid", {31'b0, valid_o}, 32'h1);
      chk("full.en", {31'b0, ram_en_o}, 32'h0);
      check_model(); advance();
      drive(1'b1, 32'h100, 1'b1);
      chk("fl.T.en", {31'b0, ram_en_o}, 32'h0);
      check_model(); advance();
      drive(1'b0, 32'h0, 1'b1);
      chk("fl.T1.valid", {31'b0, valid_o}, 32'h0);
      chk("fl.T1.en", {31'b0, ram_en_o}, 32'h1);
      chk("fl.T1.raddr", ram_addr_o, 32'h100);
      check_model(); advance();
      drive(1'b0, 32'h0, 1'b1);
      chk("fl.T2.valid", {31'b0, valid_o}, 32'h0);
      check_model(); advance();
      drive(1'b0, 32'h0, 1'b1);
      chk("fl.T3.valid", {31'b0, valid_o}, 32'h1);
      chk("fl.T3.addr", addr_o, 32'h100);
      check_model(); advance();
      repeat (4) step(1'b0, 32'h0, 1'b1);

      // Test 4: flush coinciding with a response and a pop.
      step(1'b1, 32'h200, 1'b1);
      drive(1'b0, 32'h0, 1'b1);
      chk("fl4.valid", {31'b0, valid_o}, 32'h0);
      check_model(); advance();
      repeat (4) step(1'b0, 32'h0, 1'b1);

      // Test 5: address wrap.
      step(1'b1, 32'hFFFF_FFFC, 1'b1);
      drive(1'b0, 32'h0, 1'b1);
      chk("wrap.a0", ram_addr_o, 32'hFFFF_FFFC);
      check_model(); advance();
      drive(1'b0, 32'h0, 1'b1);
      chk("wrap.a1", ram_addr_o, 32'h0000_0000);
      chk("wrap.en", {31'b0, ram_en_o}, 32'h1);
      check_model(); advance();
      repeat (6) step(1'b0, 32'h0, 1'b1);

      // Test 6: reset mid-stream with a read outstanding.
      drive(1'b0, 32'h0, 1'b1);
      rstn_i = 1'b0;
      #1;
      chk("mrst.valid", {31'b0, valid_o}, 32'h0);
      chk("mrst.en", {31'b0, ram_en_o}, 32'h0);
      @(negedge clk_i);
      release_reset();
      for (int i = 0; i < 6; i++) apply_vec("t1", t1[i]);

`ifdef JEDRO_1_PREFETCH_MISALIGN_EN
      // Test 7: unaligned redirect target.
      step(1'b1, 32'h102, 1'b1);
      drive(1'b0, 32'h0, 1'b1);
      chk("mis.T1", {31'b0, misalign_o}, 32'h1);
      chk("mis.raddr", ram_addr_o, 32'h100);
      check_model(); advance();
      drive(1'b0, 32'h0, 1'b1);
      chk("mis.T2", {31'b0, misalign_o}, 32'h0);
      check_model(); advance();
`endif

      // Randomized phase against the reference model.
      for (int i = 0; i < 600; i++) begin
         bit          fl;
         bit          rdy;
         logic [31:0] fa;
         fl  = ($urandom_range(0, 99) < 6);
         rdy = ($urandom_range(0, 99) < 65);
         fa  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
         step(fl, fa, rdy);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
